wb_regfile: RTL and testbench



---
 rtl/wb_regfile_pkg.sv | 16 +
 rtl/wb_regfile_select.sv | 26 ++
 rtl/wb_regfile.sv | 117 +++++++++++
 tb/tb_wb_regfile.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the write-back stage, register file, MEM/WB buffer
// and hazard unit: default widths, the hardwired-zero register index and the
// MemToReg select encoding.
package wb_regfile_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;
  localparam int REG_ZERO  = 0;

  // MemToReg select: which MEM/WB result is written back.
  typedef enum logic {
    SEL_ALU = 1'b0,
    SEL_MEM = 1'b1
  } wb_sel_e;

endpackage

// File: rtl/wb_regfile_select.sv
// Write-back select: 2:1 mux between the load result and the ALU result.
// Purely combinational; the output is meaningful even when no write occurs.
module wb_select
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W
) (
  input  logic              mem_to_reg_i,
  input  logic [DATA_W-1:0] mem_res_i,
  input  logic [DATA_W-1:0] alu_res_i,
  output logic [DATA_W-1:0] wb_data_o
);

  wb_sel_e sel;
  assign sel = wb_sel_e'(mem_to_reg_i);

  // Pick the memory result for loads, the ALU result otherwise.
  always_comb begin
    wb_data_o = alu_res_i;
    case (sel)
      SEL_MEM: wb_data_o = mem_res_i;
      default: wb_data_o = alu_res_i;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file.
// Selects the write-back value, commits it to a 2**ADDR_W entry register file
// (entry 0 hardwired to zero), serves two asynchronous read ports and counts
// committed writes.
// Optional feature macro: WB_BYPASS_EN -- when defined, a write committing
// this cycle is forwarded to a read port addressing the same register
// (write-first); when undefined the read ports return pre-edge contents.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_reg_write,
  input  logic              wb_mem_to_reg,
  input  logic [DATA_W-1:0] wb_mem_res,
  input  logic [DATA_W-1:0] wb_alu_res,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] wb_data,
  output logic [31:0]       wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [31:0]       wr_count_q;
  logic [31:0]       wr_count_d;
  logic              commit;

  // Write-back value selection.
  wb_select #(
    .DATA_W (DATA_W)
  ) u_select (
    .mem_to_reg_i (wb_mem_to_reg),
    .mem_res_i    (wb_mem_res),
    .alu_res_i    (wb_alu_res),
    .wb_data_o    (wb_data)
  );

  // A write commits only when enabled, targeting a non-zero register, and
  // never while reset is asserted (reset wins over a simultaneous write).
  assign commit = wb_reg_write && !rst && (wb_dest != ZERO_IDX);

  // Per-entry next state; entry 0 is tied to zero so it can never change.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      if (gi == REG_ZERO) begin : g_zero
        assign regs_d[gi] = '0;
      end else begin : g_data
        assign regs_d[gi] = (commit && (wb_dest == ADDR_W'(gi))) ? wb_data
                                                                 : regs_q[gi];
      end
    end
  endgenerate

  // Register array update with synchronous clear of every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Committed-write counter; wraps silently.
  assign wr_count_d = wr_count_q + 32'(commit);

  // Counter register, cleared by reset, updated on the commit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;

  // Two identical read ports share one description.
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;
  assign rd_data_a  = rd_data[0];
  assign rd_data_b  = rd_data[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      // Asynchronous read; index 0 reads zero regardless of array contents.
      always_comb begin
        rd_data[gi] = regs_q[rd_addr[gi]];
        if (rd_addr[gi] == ZERO_IDX) begin
          rd_data[gi] = '0;
        end
`ifdef WB_BYPASS_EN
        // Forward the value committing this cycle (commit implies a
        // non-zero destination, so index 0 is never forwarded).
        else if (commit && (rd_addr[gi] == wb_dest)) begin
          rd_data[gi] = wb_data;
        end
`endif
      end
    end
  endgenerate

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile. Stimulus pushes the expected outputs for a
// cycle into a queue; a monitor on the falling edge pops and compares.
module tb_wb_regfile;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic [31:0] wb_mem_res;
  logic [31:0] wb_alu_res;
  logic [4:0]  wb_dest;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [31:0] wb_data;
  logic [31:0] wr_count;

  wb_regfile dut (
    .clk           (clk),
    .rst           (rst),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_mem_res    (wb_mem_res),
    .wb_alu_res    (wb_alu_res),
    .wb_dest       (wb_dest),
    .rd_addr_a     (rd_addr_a),
    .rd_addr_b     (rd_addr_b),
    .rd_data_a     (rd_data_a),
    .rd_data_b     (rd_data_b),
    .wb_data       (wb_data),
    .wr_count      (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] w;
    logic [31:0] c;
  } exp_t;

  exp_t exp_q[$];
  bit   chk_v;
  int   n_cmp;
  int   n_bad;

  function automatic logic [31:0] pick(input bit byp, input logic [31:0] old_v,
                                       input logic [31:0] new_v);
    return byp ? new_v : old_v;
  endfunction

  task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", nm, fld, act, req);
    end
  endtask

  // Monitor: compare every flagged cycle against the oldest expectation.
  always @(negedge clk) begin
    if (chk_v) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard: got check with empty queue, expected an entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cmp(e.nm, "rd_data_a", rd_data_a, e.a);
        cmp(e.nm, "rd_data_b", rd_data_b, e.b);
        cmp(e.nm, "wb_data",   wb_data,   e.w);
        cmp(e.nm, "wr_count",  wr_count,  e.c);
        $display("txn %-10s a=%08h b=%08h wb=%08h cnt=%08h", e.nm,
                 rd_data_a, rd_data_b, wb_data, wr_count);
      end
    end
  end

  // One cycle: drive inputs just after the rising edge; optionally queue the
  // outputs expected before the next edge.
  task automatic cyc(input logic r, input logic we, input logic m2r,
                     input logic [31:0] mem, input logic [31:0] alu,
                     input logic [4:0] dest, input logic [4:0] ra,
                     input logic [4:0] rb, input bit chk,
                     input logic [31:0] ea, input logic [31:0] eb,
                     input logic [31:0] ew, input logic [31:0] ec,
                     input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = r;
    wb_reg_write  = we;
    wb_mem_to_reg = m2r;
    wb_mem_res    = mem;
    wb_alu_res    = alu;
    wb_dest       = dest;
    rd_addr_a     = ra;
    rd_addr_b     = rb;
    chk_v         = chk;
    if (chk) begin
      e.nm = nm; e.a = ea; e.b = eb; e.w = ew; e.c = ec;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    chk_v = 1'b0;
    rst = 1'b1; wb_reg_write = 1'b0; wb_mem_to_reg = 1'b0;
    wb_mem_res = '0; wb_alu_res = '0; wb_dest = '0;
    rd_addr_a = '0; rd_addr_b = '0;

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst0");
    cyc(1, 1, 0, 0, 32'h55, 4, 0, 0, 0, 0, 0, 0, 0, "rst1");

    // Every index reads zero after reset.
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 0, 0, 5'(i), 5'(i), 5'(i + 16), 1, 0, 0, 0, 0, "rd_reset");
    end

    // r5 <= DEADBEEF (memory result), then 12345678 (ALU result).
    cyc(0, 1, 1, 32'hDEADBEEF, 32'h12345678, 5, 5, 0, 1,
        pick(BYP, 32'h0, 32'hDEADBEEF), 0, 32'hDEADBEEF, 0, "wr_mem");
    cyc(0, 1, 0, 32'hDEADBEEF, 32'h12345678, 5, 5, 5, 1,
        pick(BYP, 32'hDEADBEEF, 32'h12345678),
        pick(BYP, 32'hDEADBEEF, 32'h12345678), 32'h12345678, 1, "wr_alu");
    // Write to r0 is ignored and not counted.
    cyc(0, 1, 0, 0, 32'hFFFFFFFF, 0, 0, 5, 1,
        0, 32'h12345678, 32'hFFFFFFFF, 2, "wr_r0");
    // Disabled write to r7 is ignored and not counted.
    cyc(0, 0, 1, 32'h77, 0, 7, 0, 7, 1, 0, 0, 32'h77, 2, "we0_r7");
    cyc(0, 0, 0, 0, 0, 0, 7, 5, 1, 0, 32'h12345678, 0, 2, "chk_r7");

    // Same-cycle write and dual read of r9.
    cyc(0, 1, 0, 0, 32'h1, 9, 9, 9, 1,
        pick(BYP, 0, 32'h1), pick(BYP, 0, 32'h1), 32'h1, 2, "r9_pre");
    cyc(0, 1, 0, 0, 32'hA5A5A5A5, 9, 9, 9, 1,
        pick(BYP, 32'h1, 32'hA5A5A5A5), pick(BYP, 32'h1, 32'hA5A5A5A5),
        32'hA5A5A5A5, 3, "r9_same");
    // Disabled write to the read index must not be forwarded.
    cyc(0, 0, 0, 0, 32'h0BAD0BAD, 9, 9, 9, 1,
        32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0BAD0BAD, 4, "r9_after");

    // Reset coincident with a write to r3: write dropped, state cleared.
    cyc(1, 1, 0, 0, 32'h11, 3, 3, 9, 1, 0, 32'hA5A5A5A5, 32'h11, 4, "rst_wr");
    cyc(0, 0, 0, 0, 0, 0, 3, 9, 1, 0, 0, 0, 0, "post_rst");

    // Counter wrap: preload near the top, then commit twice.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
    #1;
    force dut.wr_count_q = 32'hFFFFFFFE;
    #1;
    release dut.wr_count_q;
    cyc(0, 1, 0, 0, 32'h22, 2, 2, 0, 1,
        pick(BYP, 0, 32'h22), 0, 32'h22, 32'hFFFFFFFE, "wrap0");
    cyc(0, 1, 0, 0, 32'h33, 2, 2, 0, 1,
        pick(BYP, 32'h22, 32'h33), 0, 32'h33, 32'hFFFFFFFF, "wrap1");
    cyc(0, 0, 0, 0, 0, 2, 2, 2, 1, 32'h33, 32'h33, 0, 0, "wrap2");

    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "drain");
    @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
